// File: rtl/channel_sampler_pkg.sv
// Shared sizes, sample word type and pair-packing helper for channel_sampler.
package channel_sampler_pkg;
  localparam int SYNC_DEPTH = 5;
  localparam int SMPL_W     = 8;

  typedef logic [SMPL_W-1:0] smpl_t;

  // h/l carry stages 2..5 (index 1 = stage 2); newest pair lands in bit 7.
  function automatic smpl_t pack(input logic [SYNC_DEPTH-1:1] h,
                                 input logic [SYNC_DEPTH-1:1] l);
    return {h[1], l[1], h[2], l[2], h[3], l[3], h[4], l[4]};
  endfunction
endpackage

// File: rtl/chan_slice.sv
// One channel: high/low synchronizer-history chains, packed sample register.
// Optional edge outputs when CH_SAMPLE_EDGE_DET_EN is defined.
module chan_slice
  import channel_sampler_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  smpl_en,
  input  logic  wrt_smpl,
  input  logic  ch_h,
  input  logic  ch_l,
  output logic  hff5,
  output logic  lff5,
  output smpl_t smpl
`ifdef CH_SAMPLE_EDGE_DET_EN
  ,
  output logic  h_rise,
  output logic  h_fall,
  output logic  l_rise,
  output logic  l_fall
`endif
);
  // Bit 0 is stage 1 (first synchronizer flop), bit SYNC_DEPTH-1 is stage 5.
  logic [SYNC_DEPTH-1:0] hff;
  logic [SYNC_DEPTH-1:0] lff;

  always_ff @(posedge clk) begin
    if (rst) begin
      hff  <= '0;
      lff  <= '0;
      smpl <= '0;
    end else begin
      if (smpl_en) begin
        hff <= {hff[SYNC_DEPTH-2:0], ch_h};
        lff <= {lff[SYNC_DEPTH-2:0], ch_l};
      end
      if (wrt_smpl)
        smpl <= pack(hff[SYNC_DEPTH-1:1], lff[SYNC_DEPTH-1:1]);
    end
  end

  assign hff5 = hff[SYNC_DEPTH-1];
  assign lff5 = lff[SYNC_DEPTH-1];

`ifdef CH_SAMPLE_EDGE_DET_EN
  // Edge flags compare stages 4 and 5 as they stand before the shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_rise <= 1'b0;
      h_fall <= 1'b0;
      l_rise <= 1'b0;
      l_fall <= 1'b0;
    end else if (smpl_en) begin
      h_rise <=  hff[SYNC_DEPTH-2] & ~hff[SYNC_DEPTH-1];
      h_fall <= ~hff[SYNC_DEPTH-2] &  hff[SYNC_DEPTH-1];
      l_rise <=  lff[SYNC_DEPTH-2] & ~lff[SYNC_DEPTH-1];
      l_fall <= ~lff[SYNC_DEPTH-2] &  lff[SYNC_DEPTH-1];
    end
  end
`endif
endmodule

// File: rtl/channel_sampler.sv
// Multi-channel comparator sampler: NUM_CH chan_slice instances plus smpl_vld.
// Define CH_SAMPLE_EDGE_DET_EN to add the H/L rise/fall trigger outputs.
module channel_sampler
  import channel_sampler_pkg::*;
#(
  parameter int NUM_CH = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     smpl_en,
  input  logic                     wrt_smpl,
  input  logic [NUM_CH-1:0]        CH_H,
  input  logic [NUM_CH-1:0]        CH_L,
  output logic [NUM_CH-1:0]        CH_Hff5,
  output logic [NUM_CH-1:0]        CH_Lff5,
  output smpl_t [NUM_CH-1:0]       smpl,
  output logic                     smpl_vld
`ifdef CH_SAMPLE_EDGE_DET_EN
  ,
  output logic [NUM_CH-1:0]        H_rise,
  output logic [NUM_CH-1:0]        H_fall,
  output logic [NUM_CH-1:0]        L_rise,
  output logic [NUM_CH-1:0]        L_fall
`endif
);
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    chan_slice u_slice (
      .clk      (clk),
      .rst      (rst),
      .smpl_en  (smpl_en),
      .wrt_smpl (wrt_smpl),
      .ch_h     (CH_H[i]),
      .ch_l     (CH_L[i]),
      .hff5     (CH_Hff5[i]),
      .lff5     (CH_Lff5[i]),
      .smpl     (smpl[i])
`ifdef CH_SAMPLE_EDGE_DET_EN
      ,
      .h_rise   (H_rise[i]),
      .h_fall   (H_fall[i]),
      .l_rise   (L_rise[i]),
      .l_fall   (L_fall[i])
`endif
    );
  end

  always_ff @(posedge clk) begin
    if (rst) smpl_vld <= 1'b0;
    else     smpl_vld <= wrt_smpl;
  end
endmodule

// File: tb/tb_channel_sampler.sv
// Directed self-checking bench for channel_sampler (default 5 channels).
module tb_channel_sampler;
  localparam int NUM_CH = 5;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   smpl_en;
  logic                   wrt_smpl;
  logic [NUM_CH-1:0]      CH_H;
  logic [NUM_CH-1:0]      CH_L;
  logic [NUM_CH-1:0]      CH_Hff5;
  logic [NUM_CH-1:0]      CH_Lff5;
  logic [NUM_CH-1:0][7:0] smpl;
  logic                   smpl_vld;
`ifdef CH_SAMPLE_EDGE_DET_EN
  logic [NUM_CH-1:0]      H_rise, H_fall, L_rise, L_fall;
`endif

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  channel_sampler #(.NUM_CH(NUM_CH)) dut (
    .clk      (clk),
    .rst      (rst),
    .smpl_en  (smpl_en),
    .wrt_smpl (wrt_smpl),
    .CH_H     (CH_H),
    .CH_L     (CH_L),
    .CH_Hff5  (CH_Hff5),
    .CH_Lff5  (CH_Lff5),
    .smpl     (smpl),
    .smpl_vld (smpl_vld)
`ifdef CH_SAMPLE_EDGE_DET_EN
    ,
    .H_rise   (H_rise),
    .H_fall   (H_fall),
    .L_rise   (L_rise),
    .L_fall   (L_fall)
`endif
  );

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; smpl_en = 1'b0; wrt_smpl = 1'b0; CH_H = '0; CH_L = '0;
    tick(); tick();
    rst = 1'b0;
    total++;
    if (smpl !== '0) $display("FAIL reset_smpl got=%h exp=0", smpl); else passed++;
    total++;
    if (smpl_vld !== 1'b0) $display("FAIL reset_vld got=%b exp=0", smpl_vld); else passed++;
    total++;
    if (CH_Hff5 !== '0) $display("FAIL reset_hff5 got=%b exp=0", CH_Hff5); else passed++;
    total++;
    if (CH_Lff5 !== '0) $display("FAIL reset_lff5 got=%b exp=0", CH_Lff5); else passed++;
  endtask

  // ch0 H=1/L=0 -> AA; other channels H=0/L=1 -> 55.
  task automatic test_basic_pack();
    CH_H = 5'b00001; CH_L = 5'b11110; smpl_en = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 4) begin
        total++;
        if (CH_Hff5[0] !== 1'b0) $display("FAIL latency4_hff5 got=%b exp=0", CH_Hff5[0]); else passed++;
      end
    end
    total++;
    if (CH_Hff5[0] !== 1'b1) $display("FAIL latency5_hff5 got=%b exp=1", CH_Hff5[0]); else passed++;
    smpl_en = 1'b0; wrt_smpl = 1'b1;
    tick();
    wrt_smpl = 1'b0;
    total++;
    if (smpl[0] !== 8'hAA) $display("FAIL basic_smpl0 got=%h exp=aa", smpl[0]); else passed++;
    for (int i = 1; i < NUM_CH; i++) begin
      total++;
      if (smpl[i] !== 8'h55) $display("FAIL basic_smpl%0d got=%h exp=55", i, smpl[i]); else passed++;
    end
    total++;
    if (smpl_vld !== 1'b1) $display("FAIL basic_vld got=%b exp=1", smpl_vld); else passed++;
    total++;
    if (CH_Hff5[0] !== 1'b1 || CH_Lff5[0] !== 1'b0)
      $display("FAIL basic_ff5 got=%b%b exp=10", CH_Hff5[0], CH_Lff5[0]); else passed++;
    tick();
    total++;
    if (smpl_vld !== 1'b0) $display("FAIL vld_one_cycle got=%b exp=0", smpl_vld); else passed++;
    total++;
    if (smpl[0] !== 8'hAA) $display("FAIL smpl_hold got=%h exp=aa", smpl[0]); else passed++;
  endtask

  task automatic test_hold();
    smpl_en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      CH_H = (k % 2 == 0) ? 5'b11110 : 5'b00001;
      CH_L = ~CH_H;
      tick();
    end
    wrt_smpl = 1'b1;
    tick();
    wrt_smpl = 1'b0;
    total++;
    if (smpl[0] !== 8'hAA) $display("FAIL hold_smpl0 got=%h exp=aa", smpl[0]); else passed++;
    total++;
    if (CH_Hff5 !== 5'b00001) $display("FAIL hold_hff5 got=%b exp=00001", CH_Hff5); else passed++;
  endtask

  // Stage 1 primed with H=0/L=1, then capture and shift together.
  task automatic test_back_to_back();
    CH_H = '0; CH_L = '1; smpl_en = 1'b1;
    tick();
    wrt_smpl = 1'b1;
    tick();
    smpl_en = 1'b0;
    total++;
    if (smpl[0] !== 8'hAA) $display("FAIL concurrent_smpl0 got=%h exp=aa", smpl[0]); else passed++;
    tick();
    wrt_smpl = 1'b0;
    total++;
    if (smpl[0] !== 8'h6A) $display("FAIL second_wrt_smpl0 got=%h exp=6a", smpl[0]); else passed++;
    total++;
    if (smpl[1] !== 8'h55) $display("FAIL second_wrt_smpl1 got=%h exp=55", smpl[1]); else passed++;
  endtask

  task automatic capture();
    smpl_en = 1'b0; wrt_smpl = 1'b1;
    tick();
    wrt_smpl = 1'b0;
  endtask

  task automatic test_all_ones();
    CH_H = '1; CH_L = '1; smpl_en = 1'b1;
    repeat (5) tick();
    capture();
    for (int i = 0; i < NUM_CH; i++) begin
      total++;
      if (smpl[i] !== 8'hFF) $display("FAIL ones_smpl%0d got=%h exp=ff", i, smpl[i]); else passed++;
    end
    // First zero strobe only reaches stage 1, which is not packed.
    CH_H = '0; CH_L = '0; smpl_en = 1'b1;
    tick();
    capture();
    total++;
    if (smpl[2] !== 8'hFF) $display("FAIL zero1_smpl2 got=%h exp=ff", smpl[2]); else passed++;
    smpl_en = 1'b1;
    tick();
    capture();
    for (int i = 0; i < NUM_CH; i++) begin
      total++;
      if (smpl[i] !== 8'h3F) $display("FAIL zero2_smpl%0d got=%h exp=3f", i, smpl[i]); else passed++;
    end
  endtask

  task automatic test_reset_override();
    CH_H = 5'b10101; CH_L = 5'b01010; smpl_en = 1'b1;
    repeat (5) tick();
    capture();
    rst = 1'b1; wrt_smpl = 1'b1; smpl_en = 1'b1;
    tick();
    rst = 1'b0; wrt_smpl = 1'b0; smpl_en = 1'b0;
    total++;
    if (smpl !== '0) $display("FAIL rst_smpl got=%h exp=0", smpl); else passed++;
    total++;
    if (smpl_vld !== 1'b0) $display("FAIL rst_vld got=%b exp=0", smpl_vld); else passed++;
    total++;
    if (CH_Hff5 !== '0 || CH_Lff5 !== '0)
      $display("FAIL rst_ff5 got=%b/%b exp=0/0", CH_Hff5, CH_Lff5); else passed++;
    CH_H = '1; smpl_en = 1'b1;
    repeat (4) tick();
    total++;
    if (CH_Hff5 !== '0) $display("FAIL post_rst4 got=%b exp=0", CH_Hff5); else passed++;
    tick();
    smpl_en = 1'b0;
    total++;
    if (CH_Hff5 !== '1) $display("FAIL post_rst5 got=%b exp=11111", CH_Hff5); else passed++;
  endtask

`ifdef CH_SAMPLE_EDGE_DET_EN
  task automatic test_edge_det();
    rst = 1'b1; tick(); rst = 1'b0;
    CH_H = '0; CH_L = '0; smpl_en = 1'b1;
    repeat (5) tick();
    CH_H = 5'b00001;
    for (int k = 1; k <= 7; k++) begin
      tick();
      total++;
      if (H_rise[0] !== (k == 5))
        $display("FAIL h_rise_strobe%0d got=%b exp=%b", k, H_rise[0], (k == 5)); else passed++;
    end
    smpl_en = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic_pack();
    test_hold();
    test_back_to_back();
    test_all_ones();
    test_reset_override();
`ifdef CH_SAMPLE_EDGE_DET_EN
    test_edge_det();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
